cache_fill_arbiter: RTL and testbench
=====================================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
REQ-001 Parameter BLOCK_WORDS, default 8: 16-bit words per cache block.
REQ-002 Parameter MEM_LATENCY, default 4: cycles from memory request to mem_data_valid.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 icache_miss  input  1  I-cache block fill request (level).
REQ-006 icache_miss_addr  input  16  I-side miss byte address.
REQ-007 dcache_miss  input  1  D-cache block fill request (level).
REQ-008 dcache_miss_addr  input  16  D-side miss byte address.
REQ-009 dstore_req  input  1  write-through store request (level).
REQ-010 dstore_addr  input  16  store byte address.
REQ-011 dstore_data  input  16  store data.
REQ-012 mem_data_out  input  16  memory read data.
REQ-013 mem_data_valid  input  1  mem_data_out valid this cycle.
REQ-014 mem_addr  output  16  memory address.
REQ-015 mem_en  output  1  memory request strobe.
REQ-016 mem_wr  output  1  memory write, qualified by mem_en.
REQ-017 mem_data_in  output  16  memory write data.
REQ-018 fill_data  output  16  returned word to both caches.
REQ-019 fill_addr  output  16  byte address of fill_data.
REQ-020 icache_fill_we, dcache_fill_we  output  1 each  per-cache fill write enable.
REQ-021 icache_fill_done, dcache_fill_done, dstore_done  output  1 each  one-cycle completion pulses.

Function
REQ-022 FSM states IDLE, I_FILL, D_FILL, D_STORE; arbitration only in IDLE.
REQ-023 Fixed priority in IDLE: dstore_req > dcache_miss > icache_miss; no preemption once granted.
REQ-024 On grant, latch base = miss_addr & 16'hFFF0 (store: dstore_addr, dstore_data); clear issue_cnt and recv_cnt.
REQ-025 Fill states: mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt while issue_cnt < BLOCK_WORDS; issue_cnt increments per issued cycle; one request per cycle, back-to-back.
REQ-026 Fill states: fill_data = mem_data_out, fill_addr = base + 2*recv_cnt, fill_we of active cache = mem_data_valid; recv_cnt increments on each valid.
REQ-027 Last word (recv_cnt == BLOCK_WORDS-1 with mem_data_valid): assert the matching *_fill_done in that same cycle; next state IDLE.
REQ-028 Fill latency: done pulse exactly MEM_LATENCY+BLOCK_WORDS cycles after grant cycle (12 at defaults).
REQ-029 D_STORE: single cycle, mem_en=1, mem_wr=1, mem_addr/mem_data_in = latched values, dstore_done=1; next state IDLE.
REQ-030 IDLE: mem_en, mem_wr, all fill_we and done outputs 0; mem_data_valid ignored.
REQ-031 Requester deasserting mid-fill does not abort; fill completes, done still pulses.
REQ-032 Requests arriving during a fill or store wait; served from IDLE on the cycle after done (one IDLE cycle minimum between grants).
REQ-033 Miss address changing mid-fill has no effect (latched base used).
REQ-034 Counters are 4 bits wide; issue_cnt saturates at BLOCK_WORDS, no wrap.
REQ-035 Outputs are combinational decodes of state, counters and latched registers (Moore), except fill_data/fill_we, which are pass-through of memory return.

Reset
REQ-036 rst forces IDLE, issue_cnt=0, recv_cnt=0, latched base/store regs=0; all outputs 0 in the cycle following.
REQ-037 rst mid-fill abandons the block with no done pulse; memory shares rst, so no stale mem_data_valid follows.

Structure
REQ-038 Shared package: state enum encoding (IDLE=2'b00, I_FILL=2'b01, D_FILL=2'b10, D_STORE=2'b11), BLOCK_WORDS, MEM_LATENCY, block alignment mask 16'hFFF0.
REQ-039 One sub-module, fill_counter (4-bit count with enable, synchronous clear, terminal flag), instantiated for issue and receive.

Verification
REQ-040 icache_miss=1, addr 16'h0046 -> mem_addr 0x0040..0x004E over 8 cycles; icache_fill_we on 8 returns; icache_fill_done 12 cycles after grant.
REQ-041 icache_miss and dcache_miss both 1 in IDLE -> D fill (0x1230 from 0x123A) completes first, I fill granted the cycle after the IDLE following dcache_fill_done.
REQ-042 dstore_req=1 (addr 0x2002, data 0xBEEF) with dcache_miss=1 -> store cycle: mem_en=1, mem_wr=1, mem_data_in 0xBEEF, dstore_done=1; then D fill.
REQ-043 icache_miss drops after 3 issues -> all 8 words still issued and written, done pulses.
REQ-044 rst asserted at recv_cnt=5 -> IDLE next cycle, no done pulse; a fresh icache_miss then fills all 8 words correctly.
REQ-045 dstore_req asserted mid-D-fill -> store served immediately after fill returns to IDLE; no dcache_fill_we during D_STORE.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter: state encoding, block geometry
// defaults and block address helpers.
package cache_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    I_FILL  = 2'b01,
    D_FILL  = 2'b10,
    D_STORE = 2'b11
  } state_t;

  localparam int          DEF_BLOCK_WORDS = 8;
  localparam int          DEF_MEM_LATENCY = 4;
  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;

  // Byte address of 16-bit word idx within the block starting at base.
  function automatic logic [15:0] word_addr(input logic [15:0] base, input logic [3:0] idx);
    return base + {11'd0, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// 4-bit up-counter with enable, synchronous clear and a terminal-count flag.
// The owner gates i_en with o_tc where the count must saturate.
module fill_counter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int unsigned TC = DEF_BLOCK_WORDS
) (
  input  logic       clk,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [3:0] o_cnt,
  output logic       o_tc
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (i_clr)
      r_cnt <= 4'd0;
    else if (i_en)
      r_cnt <= r_cnt + 4'd1;
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == 4'(TC));

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I-cache fills, D-cache fills and write-through stores onto one
// memory port; fills issue back-to-back requests and stream returns to the caches.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int BLOCK_WORDS = DEF_BLOCK_WORDS,
  parameter int MEM_LATENCY = DEF_MEM_LATENCY
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_icache_miss,
  input  logic [15:0] i_icache_miss_addr,
  input  logic        i_dcache_miss,
  input  logic [15:0] i_dcache_miss_addr,
  input  logic        i_dstore_req,
  input  logic [15:0] i_dstore_addr,
  input  logic [15:0] i_dstore_data,
  input  logic [15:0] i_mem_data_out,
  input  logic        i_mem_data_valid,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_en,
  output logic        o_mem_wr,
  output logic [15:0] o_mem_data_in,
  output logic [15:0] o_fill_data,
  output logic [15:0] o_fill_addr,
  output logic        o_icache_fill_we,
  output logic        o_dcache_fill_we,
  output logic        o_icache_fill_done,
  output logic        o_dcache_fill_done,
  output logic        o_dstore_done
);

  if (BLOCK_WORDS < 1 || BLOCK_WORDS > 15) begin : g_bad_block_words
    $error("BLOCK_WORDS must fit a saturating 4-bit counter");
  end
  if (MEM_LATENCY < 1) begin : g_bad_mem_latency
    $error("MEM_LATENCY must be at least one cycle");
  end

  state_t      r_state;
  logic [15:0] r_base;
  logic [15:0] r_st_data;

  logic       w_fill;
  logic       w_cnt_clr;
  logic       w_issue_en;
  logic       w_recv_en;
  logic [3:0] w_issue_cnt;
  logic [3:0] w_recv_cnt;
  logic       w_issue_tc;
  logic       w_recv_tc;
  logic       w_ret_last;

  assign w_fill     = (r_state == I_FILL) || (r_state == D_FILL);
  // Counters sit cleared in IDLE, so every grant starts from zero.
  assign w_cnt_clr  = rst || (r_state == IDLE);
  assign w_issue_en = w_fill && !w_issue_tc;
  assign w_recv_en  = w_fill && i_mem_data_valid;
  assign w_ret_last = w_recv_en && w_recv_tc;

  fill_counter #(.TC(BLOCK_WORDS)) u_issue_cnt (
    .clk   (clk),
    .i_clr (w_cnt_clr),
    .i_en  (w_issue_en),
    .o_cnt (w_issue_cnt),
    .o_tc  (w_issue_tc)
  );

  fill_counter #(.TC(BLOCK_WORDS - 1)) u_recv_cnt (
    .clk   (clk),
    .i_clr (w_cnt_clr),
    .i_en  (w_recv_en),
    .o_cnt (w_recv_cnt),
    .o_tc  (w_recv_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_base    <= 16'd0;
      r_st_data <= 16'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_dstore_req) begin
            r_state   <= D_STORE;
            r_base    <= i_dstore_addr;
            r_st_data <= i_dstore_data;
          end else if (i_dcache_miss) begin
            r_state <= D_FILL;
            r_base  <= i_dcache_miss_addr & BLOCK_MASK;
          end else if (i_icache_miss) begin
            r_state <= I_FILL;
            r_base  <= i_icache_miss_addr & BLOCK_MASK;
          end
        end
        I_FILL, D_FILL: if (w_ret_last) r_state <= IDLE;
        D_STORE:        r_state <= IDLE;
        default:        r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_en      = w_issue_en || (r_state == D_STORE);
  assign o_mem_wr      = (r_state == D_STORE);
  assign o_mem_addr    = (r_state == D_STORE) ? r_base :
                         w_fill ? word_addr(r_base, w_issue_cnt) : 16'd0;
  assign o_mem_data_in = (r_state == D_STORE) ? r_st_data : 16'd0;

  assign o_fill_data        = w_fill ? i_mem_data_out : 16'd0;
  assign o_fill_addr        = w_fill ? word_addr(r_base, w_recv_cnt) : 16'd0;
  assign o_icache_fill_we   = (r_state == I_FILL) && i_mem_data_valid;
  assign o_dcache_fill_we   = (r_state == D_FILL) && i_mem_data_valid;
  assign o_icache_fill_done = (r_state == I_FILL) && w_ret_last;
  assign o_dcache_fill_done = (r_state == D_FILL) && w_ret_last;
  assign o_dstore_done      = (r_state == D_STORE);

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency memory model that
// returns (address ^ 16'hA5A5) four cycles after each read request.
module tb_cache_fill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_miss, dcache_miss, dstore_req;
  logic [15:0] icache_miss_addr, dcache_miss_addr, dstore_addr, dstore_data;
  logic [15:0] mem_data_out;
  logic        mem_data_valid;
  logic [15:0] mem_addr, mem_data_in, fill_data, fill_addr;
  logic        mem_en, mem_wr;
  logic        icache_fill_we, dcache_fill_we;
  logic        icache_fill_done, dcache_fill_done, dstore_done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_fill_arbiter dut (
    .clk                (clk),
    .rst                (rst),
    .i_icache_miss      (icache_miss),
    .i_icache_miss_addr (icache_miss_addr),
    .i_dcache_miss      (dcache_miss),
    .i_dcache_miss_addr (dcache_miss_addr),
    .i_dstore_req       (dstore_req),
    .i_dstore_addr      (dstore_addr),
    .i_dstore_data      (dstore_data),
    .i_mem_data_out     (mem_data_out),
    .i_mem_data_valid   (mem_data_valid),
    .o_mem_addr         (mem_addr),
    .o_mem_en           (mem_en),
    .o_mem_wr           (mem_wr),
    .o_mem_data_in      (mem_data_in),
    .o_fill_data        (fill_data),
    .o_fill_addr        (fill_addr),
    .o_icache_fill_we   (icache_fill_we),
    .o_dcache_fill_we   (dcache_fill_we),
    .o_icache_fill_done (icache_fill_done),
    .o_dcache_fill_done (dcache_fill_done),
    .o_dstore_done      (dstore_done)
  );

  // Memory model: read pipeline of depth 4, cleared by the shared reset.
  logic [3:0]  m_v;
  logic [15:0] m_a [4];
  always @(posedge clk) begin
    if (rst) begin
      m_v <= 4'd0;
    end else begin
      m_v <= {m_v[2:0], mem_en & ~mem_wr};
    end
    m_a[0] <= mem_addr;
    m_a[1] <= m_a[0];
    m_a[2] <= m_a[1];
    m_a[3] <= m_a[2];
  end
  assign mem_data_valid = m_v[3];
  assign mem_data_out   = m_v[3] ? (m_a[3] ^ 16'hA5A5) : 16'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, want, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " mem_en"}, 32'(mem_en), 32'd0);
    chk({tag, " mem_wr"}, 32'(mem_wr), 32'd0);
    chk({tag, " i_we"},   32'(icache_fill_we), 32'd0);
    chk({tag, " d_we"},   32'(dcache_fill_we), 32'd0);
    chk({tag, " i_done"}, 32'(icache_fill_done), 32'd0);
    chk({tag, " d_done"}, 32'(dcache_fill_done), 32'd0);
    chk({tag, " s_done"}, 32'(dstore_done), 32'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk_idle(tag);
    chk({tag, " mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, " mem_din"},   32'(mem_data_in), 32'd0);
    chk({tag, " fill_addr"}, 32'(fill_addr), 32'd0);
    chk({tag, " fill_data"}, 32'(fill_data), 32'd0);
  endtask

  task automatic chk_store(input string tag, input logic [15:0] a, input logic [15:0] d);
    chk({tag, " mem_en"},   32'(mem_en), 32'd1);
    chk({tag, " mem_wr"},   32'(mem_wr), 32'd1);
    chk({tag, " mem_addr"}, 32'(mem_addr), 32'(a));
    chk({tag, " mem_din"},  32'(mem_data_in), 32'(d));
    chk({tag, " s_done"},   32'(dstore_done), 32'd1);
    chk({tag, " d_we"},     32'(dcache_fill_we), 32'd0);
    chk({tag, " i_we"},     32'(icache_fill_we), 32'd0);
  endtask

  // Called while the grant cycle is in progress; checks the 12 cycles of a fill.
  // Cycle c: request c issued for c<8, return c-4 for c>=4, done at c==11.
  task automatic run_fill(input string tag, input logic [15:0] base, input bit is_d,
                          input int drop_c, input int store_c, input int rst_c);
    logic [15:0] ea;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk({tag, " mem_en"}, 32'(mem_en), 32'(c < 8));
      chk({tag, " mem_wr"}, 32'(mem_wr), 32'd0);
      if (c < 8) chk({tag, " mem_addr"}, 32'(mem_addr), 32'(base + 16'(2 * c)));
      chk({tag, " act_we"}, 32'(is_d ? dcache_fill_we : icache_fill_we), 32'(c >= 4));
      chk({tag, " oth_we"}, 32'(is_d ? icache_fill_we : dcache_fill_we), 32'd0);
      if (c >= 4) begin
        ea = base + 16'(2 * (c - 4));
        chk({tag, " fill_addr"}, 32'(fill_addr), 32'(ea));
        chk({tag, " fill_data"}, 32'(fill_data), 32'(ea ^ 16'hA5A5));
      end
      chk({tag, " act_done"}, 32'(is_d ? dcache_fill_done : icache_fill_done), 32'(c == 11));
      chk({tag, " oth_done"}, 32'(is_d ? icache_fill_done : dcache_fill_done), 32'd0);
      chk({tag, " s_done"}, 32'(dstore_done), 32'd0);
      if (c == drop_c) begin
        if (is_d) dcache_miss = 1'b0;
        else      icache_miss = 1'b0;
      end
      if (c == 1) begin
        icache_miss_addr = 16'hFFFF;
        dcache_miss_addr = 16'hFFFF;
      end
      if (c == store_c) begin
        dstore_req  = 1'b1;
        dstore_addr = 16'h6006;
        dstore_data = 16'h1234;
      end
      if (c == rst_c) begin
        rst = 1'b1;
        return;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    icache_miss = 1'b0; dcache_miss = 1'b0; dstore_req = 1'b0;
    icache_miss_addr = 16'd0; dcache_miss_addr = 16'd0;
    dstore_addr = 16'd0; dstore_data = 16'd0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk_zero("post_reset");

    // Basic I fill
    icache_miss = 1'b1; icache_miss_addr = 16'h0046;
    run_fill("ifill", 16'h0040, 1'b0, 0, -1, -1);
    @(negedge clk); chk_idle("ifill_end");

    // D beats I; I served after the IDLE cycle
    dcache_miss = 1'b1; dcache_miss_addr = 16'h123A;
    icache_miss = 1'b1; icache_miss_addr = 16'h0102;
    run_fill("prio_d", 16'h1230, 1'b1, 0, -1, -1);
    icache_miss_addr = 16'h0106;
    @(negedge clk); chk_idle("prio_gap");
    run_fill("prio_i", 16'h0100, 1'b0, 0, -1, -1);
    @(negedge clk); chk_idle("prio_end");

    // Store beats D miss, then D fill
    dstore_req = 1'b1; dstore_addr = 16'h2002; dstore_data = 16'hBEEF;
    dcache_miss = 1'b1; dcache_miss_addr = 16'h3456;
    @(negedge clk); chk_store("store1", 16'h2002, 16'hBEEF);
    dstore_req = 1'b0;
    @(negedge clk); chk_idle("store1_gap");
    run_fill("st_dfill", 16'h3450, 1'b1, 0, -1, -1);
    @(negedge clk); chk_idle("st_dfill_end");

    // Requester drops after three issues
    icache_miss = 1'b1; icache_miss_addr = 16'h0ABC;
    run_fill("drop", 16'h0AB0, 1'b0, 2, -1, -1);
    @(negedge clk); chk_idle("drop_end");

    // Reset with recv_cnt == 5, then a fresh fill
    icache_miss = 1'b1; icache_miss_addr = 16'h5558;
    run_fill("abort", 16'h5550, 1'b0, 0, -1, 9);
    @(negedge clk); chk_zero("abort_rst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk_zero("abort_quiet");
    end
    icache_miss = 1'b1; icache_miss_addr = 16'h7772;
    run_fill("refill", 16'h7770, 1'b0, 0, -1, -1);
    @(negedge clk); chk_idle("refill_end");

    // Store arriving mid D fill waits for the fill
    dcache_miss = 1'b1; dcache_miss_addr = 16'h4444;
    run_fill("mid_st", 16'h4440, 1'b1, 0, 5, -1);
    @(negedge clk); chk_idle("mid_st_gap");
    @(negedge clk); chk_store("store2", 16'h6006, 16'h1234);
    dstore_req = 1'b0;
    @(negedge clk); chk_idle("store2_end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
